data_mem_responder: RTL and testbench

Responder end of the core's data-memory interface. It services the MemRead/MemWrite requests that the control FSM issues, backed by a small register-array RAM. Latency is fixed and parameterised, and completion is signalled by a one-cycle ready pulse. It sits beside the register file and takes the address and write data that the core drives from register operands.

---
 rtl/data_mem_if.sv | 25 ++
 rtl/data_mem_responder.sv | 88 ++++++++
 tb/tb_data_mem_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Data-memory request/response bundle between the core's control FSM (master)
// and the data-memory responder (slave).
interface data_mem_if #(
    parameter int ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH    = 8
);
    logic                     MemRead;
    logic                     MemWrite;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     mem_ready;
    logic                     mem_busy;
    logic                     mem_err;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, mem_ready, mem_busy, mem_err
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, mem_ready, mem_busy, mem_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder backed by a register array.
// Optional `DATA_MEM_RESET_PATTERN_EN: reset loads mem[i] = i instead of 0.
module data_mem_responder #(
    parameter int          ADDRESS_WIDTH = 3,
    parameter int          DATA_WIDTH    = 8,
    parameter int unsigned WAIT_CYCLES   = 1
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_if.slave     bus
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_t;

    state_t                   state_q;
    op_t                      op_q;
    logic [3:0]               cnt_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     ready_q;
    logic                     busy_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
`ifdef DATA_MEM_RESET_PATTERN_EN
                mem_q[i] <= DATA_WIDTH'(i);
`else
                mem_q[i] <= '0;
`endif
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.MemRead || bus.MemWrite) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        op_q    <= (bus.MemRead && bus.MemWrite) ? OP_ILL :
                                   (bus.MemRead ? OP_RD : OP_WR);
                        cnt_q   <= 4'(WAIT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        case (op_q)
                            OP_RD:   rdata_q        <= mem_q[addr_q];
                            OP_WR:   mem_q[addr_q]  <= wdata_q;
                            default: err_q          <= 1'b1;
                        endcase
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Requests seen here are dropped; IDLE resamples on the next edge.
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (WAIT_CYCLES=1 main DUT,
// WAIT_CYCLES=0 DUT for the held-request back-to-back case).
module tb_data_mem_responder;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int WC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    data_mem_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    data_mem_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    data_mem_responder #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb [$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] model [2**AW];
    logic [DW-1:0] last_rd;

    function automatic logic [DW-1:0] rst_val(int i);
`ifdef DATA_MEM_RESET_PATTERN_EN
        return DW'(i);
`else
        return DW'(0) & DW'(i);
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) model[i] = rst_val(i);
        last_rd = '0;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on the WAIT_CYCLES=1 DUT and check its completion.
    task automatic do_req(string tag, logic rd, logic wr, logic [AW-1:0] a,
                          logic [DW-1:0] d, bit noisy);
        exp_t e;
        int   k;
        e.err = rd && wr;
        if (rd && !wr) begin
            e.rdata = model[a];
            last_rd = model[a];
        end else begin
            if (wr && !rd) model[a] = d;
            e.rdata = last_rd;
        end
        sb.push_back(e);

        bus.MemRead = rd; bus.MemWrite = wr; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        bus.addr = AW'($urandom); bus.wdata = DW'($urandom);
        check({tag, "/busy"}, 32'(bus.mem_busy), 32'd1);

        k = 0;
        while (!bus.mem_ready && k < 20) begin
            if (noisy) begin
                bus.MemWrite = 1'b1;
                bus.addr     = AW'($urandom);
                bus.wdata    = DW'($urandom);
            end
            @(posedge clk); #1;
            k++;
        end
        bus.MemWrite = 1'b0;
        check({tag, "/latency"}, 32'(k), 32'(WC + 1));

        e = sb.pop_front();
        check({tag, "/rdata"}, 32'(bus.rdata), 32'(e.rdata));
        check({tag, "/err"},   32'(bus.mem_err), 32'(e.err));

        @(posedge clk); #1;
        check({tag, "/ready_drop"}, 32'(bus.mem_ready), 32'd0);
        check({tag, "/err_drop"},   32'(bus.mem_err),   32'd0);
        check({tag, "/idle"},       32'(bus.mem_busy),  32'd0);
    endtask

    initial begin
        bus.MemRead = 0; bus.MemWrite = 0; bus.addr = '0; bus.wdata = '0;
        bus0.MemRead = 0; bus0.MemWrite = 0; bus0.addr = '0; bus0.wdata = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset/rdata", 32'(bus.rdata),     32'd0);
        check("reset/ready", 32'(bus.mem_ready), 32'd0);
        check("reset/busy",  32'(bus.mem_busy),  32'd0);
        check("reset/err",   32'(bus.mem_err),   32'd0);
        rst = 1'b0;

        // Read after reset, write/readback, neighbours untouched
        do_req("t1_rd5", 1, 0, 3'd5, 8'h00, 0);
        do_req("t2_wr3", 0, 1, 3'd3, 8'hA5, 0);
        do_req("t2_rd3", 1, 0, 3'd3, 8'h00, 0);
        do_req("t2_rd2", 1, 0, 3'd2, 8'h00, 0);
        do_req("t2_rd4", 1, 0, 3'd4, 8'h00, 0);

        // Illegal: both strobes; no write, rdata untouched, err pulses
        do_req("t3_rd3", 1, 0, 3'd3, 8'h00, 0);
        do_req("t3_ill", 1, 1, 3'd1, 8'hFF, 0);
        do_req("t3_rd1", 1, 0, 3'd1, 8'h00, 0);

        // Inputs churn while busy; latched values must win
        do_req("t6_wr7", 0, 1, 3'd7, 8'h5A, 1);
        do_req("t6_rd7", 1, 0, 3'd7, 8'h00, 1);
        do_req("t6_rd0", 1, 0, 3'd0, 8'h00, 1);

        // Reset mid-access
        do_req("t5_rd3", 1, 0, 3'd3, 8'h00, 0);
        bus.MemWrite = 1'b1; bus.addr = 3'd6; bus.wdata = 8'h3C;
        @(posedge clk); #1;
        bus.MemWrite = 1'b0;
        check("t5/in_wait", 32'(bus.mem_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5/rst_rdata", 32'(bus.rdata),     32'd0);
        check("t5/rst_ready", 32'(bus.mem_ready), 32'd0);
        check("t5/rst_busy",  32'(bus.mem_busy),  32'd0);
        check("t5/rst_err",   32'(bus.mem_err),   32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        do_req("t5_rd6", 1, 0, 3'd6, 8'h00, 0);
        do_req("t5_rd3b", 1, 0, 3'd3, 8'h00, 0);

        // Held request, WAIT_CYCLES=0: pulses after N+1, N+4, N+7
        bus0.addr = 3'd2; bus0.MemRead = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            check($sformatf("t4/ready_%0d", j), 32'(bus0.mem_ready), 32'(j % 3 == 1));
            check($sformatf("t4/busy_%0d", j),  32'(bus0.mem_busy),  32'(j % 3 != 2));
            if (j % 3 == 1)
                check($sformatf("t4/rdata_%0d", j), 32'(bus0.rdata), 32'(rst_val(2)));
        end
        bus0.MemRead = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t4/drained", 32'(bus0.mem_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
